huff_code_gen: RTL and testbench

- Reader side of the per-symbol merge-history memory that the sort phase of the CF Huffman datapath fills.
- After all merge steps are recorded, this block walks the NSTEP merge records in order from first merge (leaves) to last merge (root). It drives the read address and consumes two group masks per step.
- It builds the Huffman code and valid-bit mask for each of the NSYM symbols, then raises done for the output stage.

---
 rtl/huff_code_gen_pkg.sv | 24 ++
 rtl/huff_sym_acc.sv | 50 +++++
 rtl/huff_code_gen.sv | 105 ++++++++++
 tb/tb_huff_code_gen.sv | 394 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/huff_code_gen_pkg.sv
// Shared constants for the CF Huffman datapath: sizes, FSM encoding and
// symbol bit positions used by both the sort-phase writer and this reader.
package huff_code_gen_pkg;

  localparam int HC_NSYM  = 6;
  localparam int HC_NSTEP = 5;
  localparam int HC_CW    = 8;
  localparam int HC_AW    = 3;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_READ = 2'd1,
    S_DONE = 2'd2
  } hc_state_t;

  // Mask bit index of each symbol (A1 is bit 0)
  localparam int SYM_A1 = 0;
  localparam int SYM_A2 = 1;
  localparam int SYM_A3 = 2;
  localparam int SYM_A4 = 3;
  localparam int SYM_A5 = 4;
  localparam int SYM_A6 = 5;

endpackage

// File: rtl/huff_sym_acc.sv
// Per-symbol code accumulator: appends one code bit per merge step that
// names this symbol, lowest position first, so the root lands at the MSB.
module huff_sym_acc #(
  parameter int CW = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clear,
  input  logic          step_en,
  input  logic          in0,
  input  logic          in1,
  output logic [CW-1:0] code,
  output logic [CW-1:0] mask,
  output logic          err_step
);

  localparam int LW = $clog2(CW + 1);
  localparam int IW = (CW > 1) ? $clog2(CW) : 1;

  logic [LW-1:0] len;
  logic          hit;
  logic          full;
  logic [IW-1:0] idx;

  // Decode this step: a symbol in both groups takes bit 1; a full code drops bits
  always_comb begin
    hit      = in0 | in1;
    full     = (len >= LW'(CW));
    idx      = len[IW-1:0];
    err_step = step_en & ((in0 & in1) | (hit & full));
  end

  // Code, mask and length registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      code <= '0;
      mask <= '0;
      len  <= '0;
    end else if (clear) begin
      code <= '0;
      mask <= '0;
      len  <= '0;
    end else if (step_en && hit && !full) begin
      code[idx] <= in1;
      mask[idx] <= 1'b1;
      len       <= len + LW'(1);
    end
  end

endmodule

// File: rtl/huff_code_gen.sv
// Merge-history reader: walks the recorded merge steps leaf-to-root,
// drives the history read address and builds per-symbol Huffman codes.
module huff_code_gen
  import huff_code_gen_pkg::*;
#(
  parameter int NSYM  = HC_NSYM,
  parameter int NSTEP = HC_NSTEP,
  parameter int CW    = HC_CW,
  parameter int AW    = HC_AW
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  output logic [AW-1:0]      rd_addr,
  input  logic [NSYM-1:0]    grp0_mask,
  input  logic [NSYM-1:0]    grp1_mask,
  output logic               busy,
  output logic               done,
  output logic               valid,
  output logic               err,
  output logic [NSYM*CW-1:0] hc,
  output logic [NSYM*CW-1:0] m
);

  hc_state_t       state;
  logic            pend;
  logic            clr;
  logic            step_en;
  logic            step_err;
  logic [NSYM-1:0] sym_err;

  // Accept a start (fresh or held over from DONE) only in IDLE; step only in READ
  always_comb begin
    clr      = (state == S_IDLE) && (start || pend);
    step_en  = (state == S_READ);
    step_err = step_en &&
               ((|sym_err) || (grp0_mask == '0) || (grp1_mask == '0));
  end

  // Control FSM with registered handshake outputs and read address
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= S_IDLE;
      rd_addr <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      valid   <= 1'b0;
      err     <= 1'b0;
      pend    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          rd_addr <= '0;
          if (start || pend) begin
            state <= S_READ;
            busy  <= 1'b1;
            valid <= 1'b0;
            err   <= 1'b0;
            pend  <= 1'b0;
          end
        end
        S_READ: begin
          if (step_err) err <= 1'b1;
          if (rd_addr == AW'(NSTEP - 1)) begin
            state   <= S_DONE;
            busy    <= 1'b0;
            done    <= 1'b1;
            valid   <= 1'b1;
            rd_addr <= '0;
          end else begin
            rd_addr <= rd_addr + AW'(1);
          end
        end
        S_DONE: begin
          state   <= S_IDLE;
          rd_addr <= '0;
          if (start) pend <= 1'b1;
        end
        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  // One accumulator per symbol, packed into the hc/m output buses
  for (genvar i = 0; i < NSYM; i++) begin : g_sym
    huff_sym_acc #(
      .CW(CW)
    ) u_acc (
      .clk      (clk),
      .reset    (reset),
      .clear    (clr),
      .step_en  (step_en),
      .in0      (grp0_mask[i]),
      .in1      (grp1_mask[i]),
      .code     (hc[i*CW +: CW]),
      .mask     (m[i*CW +: CW]),
      .err_step (sym_err[i])
    );
  end

endmodule

// File: tb/tb_huff_code_gen.sv
// Testbench for huff_code_gen: merge-history tables drive the read port,
// results are compared with fixed tables and a tree-walk reference model.
module tb_huff_code_gen;
  import huff_code_gen_pkg::*;

  localparam int NSYM  = HC_NSYM;
  localparam int NSTEP = HC_NSTEP;
  localparam int CW    = HC_CW;
  localparam int AW    = HC_AW;

  logic               clk = 1'b0;
  logic               reset;
  logic               start;
  logic [AW-1:0]      rd_addr;
  logic [NSYM-1:0]    grp0_mask;
  logic [NSYM-1:0]    grp1_mask;
  logic               busy;
  logic               done;
  logic               valid;
  logic               err;
  logic [NSYM*CW-1:0] hc;
  logic [NSYM*CW-1:0] m;

  logic [NSYM-1:0] g0 [NSTEP];
  logic [NSYM-1:0] g1 [NSTEP];
  logic [CW-1:0]   exp_hc [NSYM];
  logic [CW-1:0]   exp_m  [NSYM];
  logic            exp_err;

  int n_tests = 0;
  int n_fail  = 0;
  int lat;
  int addr_q[$];

  always #5 clk = ~clk;

  // History memory: combinational read at rd_addr
  always_comb begin
    grp0_mask = '0;
    grp1_mask = '0;
    if (int'(rd_addr) < NSTEP) begin
      grp0_mask = g0[int'(rd_addr)];
      grp1_mask = g1[int'(rd_addr)];
    end
  end

  huff_code_gen dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .rd_addr   (rd_addr),
    .grp0_mask (grp0_mask),
    .grp1_mask (grp1_mask),
    .busy      (busy),
    .done      (done),
    .valid     (valid),
    .err       (err),
    .hc        (hc),
    .m         (m)
  );

  // Reference: walk steps in order, appending a bit per naming for each symbol
  task automatic model_compute();
    int len [NSYM];
    exp_err = 1'b0;
    for (int i = 0; i < NSYM; i++) begin
      exp_hc[i] = '0;
      exp_m[i]  = '0;
      len[i]    = 0;
    end
    for (int s = 0; s < NSTEP; s++) begin
      if (g0[s] == 0 || g1[s] == 0) exp_err = 1'b1;
      for (int i = 0; i < NSYM; i++) begin
        if (g0[s][i] && g1[s][i]) exp_err = 1'b1;
        if (g0[s][i] || g1[s][i]) begin
          if (len[i] < CW) begin
            if (g1[s][i]) exp_hc[i] = exp_hc[i] | (CW'(1) << len[i]);
            exp_m[i] = exp_m[i] | (CW'(1) << len[i]);
            len[i]++;
          end else begin
            exp_err = 1'b1;
          end
        end
      end
    end
  endtask

  task automatic load_skewed();
    g0[0] = 6'b010000; g1[0] = 6'b100000;
    g0[1] = 6'b001000; g1[1] = 6'b110000;
    g0[2] = 6'b000100; g1[2] = 6'b111000;
    g0[3] = 6'b000010; g1[3] = 6'b111100;
    g0[4] = 6'b000001; g1[4] = 6'b111110;
  endtask

  task automatic load_balanced();
    g0[0] = 6'b000001; g1[0] = 6'b000010;
    g0[1] = 6'b000100; g1[1] = 6'b001000;
    g0[2] = 6'b010000; g1[2] = 6'b100000;
    g0[3] = 6'b000011; g1[3] = 6'b001100;
    g0[4] = 6'b001111; g1[4] = 6'b110000;
  endtask

  // Pulse start, optionally pulse it again mid-read, wait (bounded) for done
  task automatic run_op(input int restart_at);
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    lat = 1;
    addr_q.delete();
    while (!done && lat < 50) begin
      if (busy) addr_q.push_back(int'(rd_addr));
      start = (lat == restart_at);
      @(negedge clk);
      lat++;
    end
    start = 1'b0;
    if (!done) begin
      n_tests++; n_fail++;
      $display("FAIL run_timeout: done=%0b after %0d cycles, required 1", done, lat);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    start = 1'b0;
    repeat (2) @(negedge clk);
    n_tests++;
    if ({busy, done, valid, err} !== 4'b0000) begin
      n_fail++;
      $display("FAIL reset_flags: busy/done/valid/err=%b required 0000", {busy, done, valid, err});
    end
    n_tests++;
    if (rd_addr !== '0) begin
      n_fail++;
      $display("FAIL reset_addr: rd_addr=%0d required 0", rd_addr);
    end
    n_tests++;
    if (hc !== '0 || m !== '0) begin
      n_fail++;
      $display("FAIL reset_codes: hc=%h m=%h required 0", hc, m);
    end
    @(negedge clk) reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_skewed();
    logic [CW-1:0] rhc [NSYM];
    logic [CW-1:0] rm  [NSYM];
    rhc = '{8'h00, 8'h02, 8'h06, 8'h0E, 8'h1E, 8'h1F};
    rm  = '{8'h01, 8'h03, 8'h07, 8'h0F, 8'h1F, 8'h1F};
    load_skewed();
    run_op(0);
    n_tests++;
    if (lat !== 6) begin
      n_fail++;
      $display("FAIL skew_latency: done in cycle %0d required 6", lat);
    end
    n_tests++;
    if (err !== 1'b0 || valid !== 1'b1) begin
      n_fail++;
      $display("FAIL skew_flags: err=%b valid=%b required err=0 valid=1", err, valid);
    end
    for (int i = 0; i < NSYM; i++) begin
      n_tests++;
      if (hc[i*CW +: CW] !== rhc[i] || m[i*CW +: CW] !== rm[i]) begin
        n_fail++;
        $display("FAIL skew_A%0d: hc=%h m=%h required hc=%h m=%h",
                 i + 1, hc[i*CW +: CW], m[i*CW +: CW], rhc[i], rm[i]);
      end
    end
  endtask

  task automatic test_balanced();
    logic [CW-1:0] rhc [NSYM];
    logic [CW-1:0] rm  [NSYM];
    rhc = '{8'h00, 8'h01, 8'h02, 8'h03, 8'h02, 8'h03};
    rm  = '{8'h07, 8'h07, 8'h07, 8'h07, 8'h03, 8'h03};
    load_balanced();
    run_op(0);
    n_tests++;
    if (err !== 1'b0) begin
      n_fail++;
      $display("FAIL bal_err: err=%b required 0", err);
    end
    for (int i = 0; i < NSYM; i++) begin
      n_tests++;
      if (hc[i*CW +: CW] !== rhc[i] || m[i*CW +: CW] !== rm[i]) begin
        n_fail++;
        $display("FAIL bal_A%0d: hc=%h m=%h required hc=%h m=%h",
                 i + 1, hc[i*CW +: CW], m[i*CW +: CW], rhc[i], rm[i]);
      end
    end
  endtask

  task automatic test_malformed();
    load_skewed();
    g1[2] = g1[2] | 6'b000100;
    model_compute();
    run_op(0);
    n_tests++;
    if (err !== 1'b1) begin
      n_fail++;
      $display("FAIL mal_err: err=%b required 1", err);
    end
    n_tests++;
    if (hc[SYM_A3*CW] !== 1'b1) begin
      n_fail++;
      $display("FAIL mal_A3_bit0: got %b required 1", hc[SYM_A3*CW]);
    end
    for (int i = 0; i < NSYM; i++) begin
      n_tests++;
      if (hc[i*CW +: CW] !== exp_hc[i] || m[i*CW +: CW] !== exp_m[i]) begin
        n_fail++;
        $display("FAIL mal_A%0d: hc=%h m=%h required hc=%h m=%h",
                 i + 1, hc[i*CW +: CW], m[i*CW +: CW], exp_hc[i], exp_m[i]);
      end
    end
    load_skewed();
    run_op(0);
    n_tests++;
    if (err !== 1'b0 || hc[SYM_A3*CW +: CW] !== 8'h06) begin
      n_fail++;
      $display("FAIL mal_clean_rerun: err=%b A3=%h required err=0 A3=06",
               err, hc[SYM_A3*CW +: CW]);
    end
  endtask

  task automatic test_reset_mid();
    load_skewed();
    model_compute();
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    #1;
    n_tests++;
    if (hc !== '0 || m !== '0) begin
      n_fail++;
      $display("FAIL midrst_codes: hc=%h m=%h required 0", hc, m);
    end
    n_tests++;
    if (busy !== 1'b0 || rd_addr !== '0 || valid !== 1'b0) begin
      n_fail++;
      $display("FAIL midrst_ctrl: busy=%b rd_addr=%0d valid=%b required 0/0/0",
               busy, rd_addr, valid);
    end
    @(negedge clk) reset = 1'b0;
    @(negedge clk);
    run_op(0);
    for (int i = 0; i < NSYM; i++) begin
      n_tests++;
      if (hc[i*CW +: CW] !== exp_hc[i] || m[i*CW +: CW] !== exp_m[i]) begin
        n_fail++;
        $display("FAIL midrst_rerun_A%0d: hc=%h m=%h required hc=%h m=%h",
                 i + 1, hc[i*CW +: CW], m[i*CW +: CW], exp_hc[i], exp_m[i]);
      end
    end
  endtask

  task automatic test_handshake();
    int cyc;
    load_balanced();
    model_compute();
    run_op(2);
    n_tests++;
    if (lat !== 6) begin
      n_fail++;
      $display("FAIL hs_ignore_restart: done in cycle %0d required 6", lat);
    end
    n_tests++;
    if (addr_q.size() !== NSTEP) begin
      n_fail++;
      $display("FAIL hs_addr_count: %0d reads required %0d", addr_q.size(), NSTEP);
    end else begin
      for (int k = 0; k < NSTEP; k++) begin
        n_tests++;
        if (addr_q[k] !== k) begin
          n_fail++;
          $display("FAIL hs_addr_seq[%0d]: rd_addr=%0d required %0d", k, addr_q[k], k);
        end
      end
    end
    @(negedge clk);
    n_tests++;
    if (done !== 1'b0 || busy !== 1'b0 || rd_addr !== '0) begin
      n_fail++;
      $display("FAIL hs_done_pulse: done=%b busy=%b rd_addr=%0d required 0/0/0",
               done, busy, rd_addr);
    end
    repeat (3) @(negedge clk);
    n_tests++;
    if (valid !== 1'b1 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL hs_valid_hold: valid=%b busy=%b required 1/0", valid, busy);
    end
    // Start coinciding with done
    load_skewed();
    model_compute();
    run_op(0);
    start = 1'b1;
    @(negedge clk) start = 1'b0;
    @(negedge clk);
    n_tests++;
    if (busy !== 1'b1 || valid !== 1'b0 || rd_addr !== '0) begin
      n_fail++;
      $display("FAIL hs_start_at_done: busy=%b valid=%b rd_addr=%0d required 1/0/0",
               busy, valid, rd_addr);
    end
    cyc = 0;
    while (!done && cyc < 50) begin
      @(negedge clk);
      cyc++;
    end
    n_tests++;
    if (done !== 1'b1) begin
      n_fail++;
      $display("FAIL hs_restart_done: done=%b required 1", done);
    end
    for (int i = 0; i < NSYM; i++) begin
      n_tests++;
      if (hc[i*CW +: CW] !== exp_hc[i] || m[i*CW +: CW] !== exp_m[i]) begin
        n_fail++;
        $display("FAIL hs_restart_A%0d: hc=%h m=%h required hc=%h m=%h",
                 i + 1, hc[i*CW +: CW], m[i*CW +: CW], exp_hc[i], exp_m[i]);
      end
    end
  endtask

  task automatic test_random();
    logic [NSYM-1:0] grp[$];
    int a;
    int b;
    logic [NSYM-1:0] ma;
    logic [NSYM-1:0] mb;
    for (int it = 0; it < 24; it++) begin
      if (it % 2 == 0) begin
        // Legal tree: repeatedly merge two random live groups
        grp.delete();
        for (int i = 0; i < NSYM; i++) grp.push_back(NSYM'(1) << i);
        for (int s = 0; s < NSTEP; s++) begin
          a = $urandom_range(0, grp.size() - 1);
          b = $urandom_range(0, grp.size() - 2);
          if (b >= a) b++;
          ma = grp[a];
          mb = grp[b];
          g0[s] = ma;
          g1[s] = mb;
          if (a > b) begin grp.delete(a); grp.delete(b); end
          else       begin grp.delete(b); grp.delete(a); end
          grp.push_back(ma | mb);
        end
      end else begin
        for (int s = 0; s < NSTEP; s++) begin
          g0[s] = ($urandom_range(0, 5) == 0) ? '0 : NSYM'($urandom);
          g1[s] = NSYM'($urandom);
        end
      end
      model_compute();
      run_op(0);
      n_tests++;
      if (err !== exp_err) begin
        n_fail++;
        $display("FAIL rand%0d_err: err=%b required %b", it, err, exp_err);
      end
      for (int i = 0; i < NSYM; i++) begin
        n_tests++;
        if (hc[i*CW +: CW] !== exp_hc[i] || m[i*CW +: CW] !== exp_m[i]) begin
          n_fail++;
          $display("FAIL rand%0d_A%0d: hc=%h m=%h required hc=%h m=%h",
                   it, i + 1, hc[i*CW +: CW], m[i*CW +: CW], exp_hc[i], exp_m[i]);
        end
      end
    end
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0;
    for (int s = 0; s < NSTEP; s++) begin
      g0[s] = '0;
      g1[s] = '0;
    end
    test_reset();
    test_skewed();
    test_balanced();
    test_malformed();
    test_reset_mid();
    test_handshake();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
